// File: rtl/mux_arb_n_if.sv
// Bus bundle for the N-channel arbitrated mux: per-channel producer side
// (data/valid/ready, mask, mode) and the single registered consumer side.
interface mux_arb_n_if #(
    parameter int WIDTH = 4,
    parameter int N     = 4,
    parameter int IDW   = $clog2(N)
);
    logic                 mode;
    logic [N-1:0]         ch_mask;
    logic [N*WIDTH-1:0]   data_in;
    logic [N-1:0]         valid_in;
    logic [N-1:0]         ready_out;
    logic [WIDTH-1:0]     data_out;
    logic [IDW-1:0]       chan_out;
    logic                 valid_out;
    logic                 ready_in;

    // Arbiter side: consumes channel requests, drives the registered output.
    modport slave (
        input  mode, ch_mask, data_in, valid_in, ready_in,
        output ready_out, data_out, chan_out, valid_out
    );

    // Environment side: producers plus downstream consumer.
    modport master (
        output mode, ch_mask, data_in, valid_in, ready_in,
        input  ready_out, data_out, chan_out, valid_out
    );
endinterface

// File: rtl/mux_arb_n.sv
// N-channel registered arbitrated multiplexer. One channel per cycle is
// granted (round-robin from a rotating pointer, or lowest-index-first) and
// its word is captured, with its channel index, into a single output register.
module mux_arb_n #(
    parameter int WIDTH = 4,
    parameter int N     = 4,
    parameter int IDW   = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    mux_arb_n_if.slave     bus
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [IDW-1:0]   chan_q, chan_d;
    logic             valid_q, valid_d;
    logic [IDW-1:0]   ptr_q, ptr_d;

    logic             load;
    logic [N-1:0]     req;
    logic             gnt_vld;
    logic [IDW-1:0]   gnt_idx;
    logic [N-1:0]     gnt_onehot;
    logic [WIDTH-1:0] gnt_data;

    assign load = !valid_q || bus.ready_in;
    assign req  = bus.valid_in & bus.ch_mask;

    // Grant selection: loops run from the far end downwards so the last hit
    // written is the winner nearest the search start.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (load && (|req)) begin
            gnt_vld = 1'b1;
            if (bus.mode) begin
                for (int i = N - 1; i >= 0; i--) begin
                    if (req[i]) gnt_idx = IDW'(i);
                end
            end else begin
                for (int k = N - 1; k >= 0; k--) begin
                    idx = int'(ptr_q) + k;
                    if (idx >= N) idx = idx - N;
                    if (req[idx]) gnt_idx = IDW'(idx);
                end
            end
        end
    end

    // Grant decode and data select; ready is suppressed while reset is held
    // so no producer sees a handshake that the cleared registers will ignore.
    always_comb begin
        gnt_onehot          = '0;
        gnt_onehot[gnt_idx] = gnt_vld & ~reset;
        gnt_data            = bus.data_in[int'(gnt_idx) * WIDTH +: WIDTH];
    end

    assign bus.ready_out = gnt_onehot;

    // Next-state: capture on grant, drop valid on an empty load slot, hold on stall.
    always_comb begin
        data_d  = data_q;
        chan_d  = chan_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (load) begin
            if (gnt_vld) begin
                data_d  = gnt_data;
                chan_d  = gnt_idx;
                valid_d = 1'b1;
                if (!bus.mode) begin
                    ptr_d = (gnt_idx == IDW'(N - 1)) ? '0 : gnt_idx + IDW'(1);
                end
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.data_out  = data_q;
    assign bus.chan_out  = chan_q;
    assign bus.valid_out = valid_q;

endmodule

// File: tb/tb_mux_arb_n.sv
module tb_mux_arb_n;

    logic clk;
    logic reset;

    mux_arb_n_if #(.WIDTH(4), .N(4)) bus ();

    mux_arb_n #(.WIDTH(4), .N(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] d;
        logic [1:0] c;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [3:0] d, input logic [1:0] c);
        exp_t e;
        e.d = d;
        e.c = c;
        sb.push_back(e);
    endtask

    // Check ready_out mid-cycle, then advance to just after the next rising edge.
    task automatic cyc(input string name, input logic [3:0] exp_ro);
        @(negedge clk);
        chk(name, 32'(bus.ready_out), 32'(exp_ro));
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every output transfer pops one expected word.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.valid_out && bus.ready_in) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_word: got data %0h chan %0d with empty queue", bus.data_out, bus.chan_out);
            end else begin
                e = sb.pop_front();
                chk("sb_data", 32'(bus.data_out), 32'(e.d));
                chk("sb_chan", 32'(bus.chan_out), 32'(e.c));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ch_data [4];
        ch_data[0] = 4'hA; ch_data[1] = 4'hB; ch_data[2] = 4'hC; ch_data[3] = 4'hD;

        reset        = 1'b1;
        bus.mode     = 1'b0;
        bus.ch_mask  = 4'hF;
        bus.data_in  = 16'hDCBA;
        bus.valid_in = 4'h0;
        bus.ready_in = 1'b1;

        @(negedge clk);
        chk("rst_valid_out", 32'(bus.valid_out), 0);
        chk("rst_data_out", 32'(bus.data_out), 0);
        chk("rst_chan_out", 32'(bus.chan_out), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Round-robin over all four channels, twice.
        bus.valid_in = 4'hF;
        for (int i = 0; i < 8; i++) begin
            push_exp(ch_data[i % 4], 2'(i % 4));
            cyc("rr_ready", 4'(1 << (i % 4)));
        end

        // Fixed priority: channel 0 always wins.
        bus.mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_exp(4'hA, 2'd0);
            cyc("fp_ready", 4'b0001);
        end

        // Backpressure with the last A/0 word held in the output register.
        bus.mode     = 1'b0;
        bus.ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc("bp_ready", 4'b0000);
            chk("bp_data_hold", 32'(bus.data_out), 32'hA);
            chk("bp_chan_hold", 32'(bus.chan_out), 0);
            chk("bp_valid_hold", 32'(bus.valid_out), 1);
        end
        bus.ready_in = 1'b1;
        push_exp(4'hA, 2'd0);
        cyc("bp_release0", 4'b0001);
        push_exp(4'hB, 2'd1);
        cyc("bp_release1", 4'b0010);

        // Sparse requests with channel 3 masked off, then unmasked.
        bus.valid_in = 4'b1010;
        bus.ch_mask  = 4'b0111;
        for (int i = 0; i < 2; i++) begin
            push_exp(4'hB, 2'd1);
            cyc("mask_ch1", 4'b0010);
        end
        bus.ch_mask = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                push_exp(4'hD, 2'd3);
                cyc("sparse_ch3", 4'b1000);
            end else begin
                push_exp(4'hB, 2'd1);
                cyc("sparse_ch1", 4'b0010);
            end
        end

        // Idle: last word drains, then valid_out drops and data holds.
        bus.valid_in = 4'h0;
        @(negedge clk);
        chk("idle_valid_last", 32'(bus.valid_out), 1);
        chk("idle_ready", 32'(bus.ready_out), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("idle_valid_drop", 32'(bus.valid_out), 0);
        chk("idle_data_hold", 32'(bus.data_out), 32'hB);
        chk("idle_chan_hold", 32'(bus.chan_out), 1);
        @(posedge clk);
        #1;

        // Reset mid-stream: a held word (ch2, pointer at 2) must be discarded.
        bus.ready_in = 1'b0;
        bus.valid_in = 4'hF;
        cyc("pre_rst_grant", 4'b0100);
        chk("pre_rst_data", 32'(bus.data_out), 32'hC);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", 32'(bus.valid_out), 0);
        chk("async_rst_data", 32'(bus.data_out), 0);
        chk("async_rst_chan", 32'(bus.chan_out), 0);
        chk("async_rst_ready", 32'(bus.ready_out), 0);
        bus.ready_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc("in_rst_ready", 4'b0000);
        end
        reset = 1'b0;
        push_exp(4'hA, 2'd0);
        cyc("post_rst_ch0", 4'b0001);
        bus.valid_in = 4'h0;
        cyc("post_rst_idle", 4'b0000);
        cyc("post_rst_idle2", 4'b0000);

        chk("sb_empty", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
